// File: rtl/dma_pkg.sv
// Shared definitions for the SRAM write DMA and the ROM read DMA; SRAM_DMA_WR_VERIFY_EN adds the VERIFY state.
// Both controllers run from one 20 ns clock, so the phase constants below are counts of 20 ns cycles.
package dma_pkg;

    localparam int DEF_SETUP_CYCLES     = 1;
    localparam int DEF_WR_PULSE_CYCLES  = 4;
    localparam int DEF_HOLD_CYCLES      = 1;
    localparam int DEF_RD_STABLE_CYCLES = 8;

`ifdef SRAM_DMA_WR_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR_SETUP = 3'd1,
        ST_WE_PULSE   = 3'd2,
        ST_HOLD       = 3'd3,
        ST_VERIFY     = 3'd4
    } t_sram_wr_states;
`else
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR_SETUP = 3'd1,
        ST_WE_PULSE   = 3'd2,
        ST_HOLD       = 3'd3
    } t_sram_wr_states;
`endif

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dma_phase_timer.sv
// Loadable down-counter for strobe phase lengths; tc_o is high while the count is zero.
// Loading N-1 gives a phase of N cycles ending on the cycle tc_o is seen high.
module dma_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sram_dma_wr_ctrl.sv
// SRAM write DMA: pops show-ahead FIFO bytes and writes them to consecutive addresses, 1+SETUP+PULSE+HOLD cycles/byte.
// Waits in IDLE while the FIFO is empty; SRAM_DMA_WR_VERIFY_EN adds a sticky readback compare after each write.
module sram_dma_wr_ctrl
    import dma_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH   = 16,
    parameter int MEM_DATA_WIDTH   = 8,
    parameter int SETUP_CYCLES     = DEF_SETUP_CYCLES,
    parameter int WR_PULSE_CYCLES  = DEF_WR_PULSE_CYCLES,
    parameter int HOLD_CYCLES      = DEF_HOLD_CYCLES,
    parameter int RD_STABLE_CYCLES = DEF_RD_STABLE_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_data_out,
    input  logic                       fifo_empty,
    output logic                       fifo_pop,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [MEM_DATA_WIDTH-1:0]  mem_wr_data,
    output logic                       mem_data_oe,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_rd_data,
    output logic                       CE_bar,
    output logic                       OE_bar,
    output logic                       WE_bar,
    input  logic                       start_wr,
    input  logic                       cfg_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]  cfg_dma_base_addr,
    input  logic [MEM_ADDR_WIDTH-1:0]  cfg_dma_num_bytes,
    output logic                       batch_dma_done,
    output logic                       busy,
    output logic                       verify_err
);

    localparam int TMR_W = $clog2(max_of4(SETUP_CYCLES, WR_PULSE_CYCLES,
                                          HOLD_CYCLES, RD_STABLE_CYCLES) + 1);

    t_sram_wr_states            state_q;
    logic [MEM_ADDR_WIDTH-1:0]  base_q;
    logic [MEM_ADDR_WIDTH-1:0]  byte_cntr_q;
    logic [MEM_ADDR_WIDTH-1:0]  addr_q;
    logic [MEM_DATA_WIDTH-1:0]  data_reg_q;
    logic                       ce_bar_q;
    logic                       oe_bar_q;
    logic                       we_bar_q;
    logic                       data_oe_q;

    logic                       cfg_reload;
    logic                       go;
    logic                       tmr_tc;
    logic                       tmr_load_d;
    logic [TMR_W-1:0]           tmr_val_d;

    assign cfg_reload     = !start_wr && !cfg_ready;
    assign batch_dma_done = (byte_cntr_q == cfg_dma_num_bytes);
    assign go             = start_wr && cfg_ready && !batch_dma_done && !fifo_empty;
    assign fifo_pop       = reset_n && (state_q == ST_IDLE) && go;
    assign busy           = (state_q != ST_IDLE);

    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_reg_q;
    assign mem_data_oe = data_oe_q;
    assign CE_bar      = ce_bar_q;
    assign OE_bar      = oe_bar_q;
    assign WE_bar      = we_bar_q;

    // The timer is reloaded with the length of the phase about to start on every state change.
    always_comb begin
        tmr_load_d = (state_q == ST_IDLE) || tmr_tc;
        tmr_val_d  = '0;
        case (state_q)
            ST_IDLE:       tmr_val_d = TMR_W'(SETUP_CYCLES - 1);
            ST_ADDR_SETUP: tmr_val_d = TMR_W'(WR_PULSE_CYCLES - 1);
            ST_WE_PULSE:   tmr_val_d = TMR_W'(HOLD_CYCLES - 1);
            ST_HOLD:       tmr_val_d = TMR_W'(RD_STABLE_CYCLES - 1);
            default:       tmr_val_d = '0;
        endcase
    end

    dma_phase_timer #(
        .W (TMR_W)
    ) u_phase_tmr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .tc_o       (tmr_tc)
    );

`ifdef SRAM_DMA_WR_VERIFY_EN
    logic verify_err_q;
    assign verify_err = verify_err_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^mem_rd_data;
    assign verify_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            byte_cntr_q <= '0;
            addr_q      <= '0;
            data_reg_q  <= '0;
            ce_bar_q    <= 1'b1;
            oe_bar_q    <= 1'b1;
            we_bar_q    <= 1'b1;
            data_oe_q   <= 1'b0;
`ifdef SRAM_DMA_WR_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            if (cfg_reload) begin
                byte_cntr_q <= '0;
                base_q      <= cfg_dma_base_addr;
            end else if (state_q == ST_HOLD && tmr_tc) begin
                byte_cntr_q <= byte_cntr_q + 1'b1;
            end
`ifdef SRAM_DMA_WR_VERIFY_EN
            if (cfg_reload) begin
                verify_err_q <= 1'b0;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q    <= ST_ADDR_SETUP;
                        data_reg_q <= MEM_DATA_WIDTH'(fifo_data_out);
                        addr_q     <= base_q + byte_cntr_q;
                        ce_bar_q   <= 1'b0;
                        data_oe_q  <= 1'b1;
                    end
                end
                ST_ADDR_SETUP: begin
                    if (tmr_tc) begin
                        state_q  <= ST_WE_PULSE;
                        we_bar_q <= 1'b0;
                    end
                end
                ST_WE_PULSE: begin
                    if (tmr_tc) begin
                        state_q  <= ST_HOLD;
                        we_bar_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
`ifdef SRAM_DMA_WR_VERIFY_EN
                        state_q   <= ST_VERIFY;
                        oe_bar_q  <= 1'b0;
                        data_oe_q <= 1'b0;
`else
                        state_q    <= ST_IDLE;
                        ce_bar_q   <= 1'b1;
                        data_oe_q  <= 1'b0;
                        addr_q     <= '0;
                        data_reg_q <= '0;
`endif
                    end
                end
`ifdef SRAM_DMA_WR_VERIFY_EN
                // Address stays driven so the SRAM read settles; the compare uses the last settle cycle.
                ST_VERIFY: begin
                    if (tmr_tc) begin
                        state_q    <= ST_IDLE;
                        ce_bar_q   <= 1'b1;
                        oe_bar_q   <= 1'b1;
                        addr_q     <= '0;
                        data_reg_q <= '0;
                        if (mem_rd_data != data_reg_q) begin
                            verify_err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_dma_wr_ctrl.sv
// Randomized bench for sram_dma_wr_ctrl: FIFO and SRAM models, write monitor, and a byte-list scoreboard.
module tb_sram_dma_wr_ctrl;

    localparam int SETUP = 1;
    localparam int PULSE = 4;
    localparam int HOLD  = 1;
    localparam int RDS   = 8;
`ifdef SRAM_DMA_WR_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    localparam int PER = 1 + SETUP + PULSE + HOLD + VER * RDS;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  fifo_data_out;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [15:0] mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_data_oe;
    logic [7:0]  mem_rd_data;
    logic        CE_bar, OE_bar, WE_bar;
    logic        start_wr, cfg_ready;
    logic [15:0] cfg_base, cfg_num;
    logic        batch_dma_done, busy, verify_err;

    always #10 clk = ~clk;

    sram_dma_wr_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .fifo_data_out     (fifo_data_out),
        .fifo_empty        (fifo_empty),
        .fifo_pop          (fifo_pop),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_data_oe       (mem_data_oe),
        .mem_rd_data       (mem_rd_data),
        .CE_bar            (CE_bar),
        .OE_bar            (OE_bar),
        .WE_bar            (WE_bar),
        .start_wr          (start_wr),
        .cfg_ready         (cfg_ready),
        .cfg_dma_base_addr (cfg_base),
        .cfg_dma_num_bytes (cfg_num),
        .batch_dma_done    (batch_dma_done),
        .busy              (busy),
        .verify_err        (verify_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO model: show-ahead queue, pop on the clock edge where fifo_pop was high.
    logic [7:0] fifo_q[$];
    logic       fifo_hold;
    always @(posedge clk) begin
        if (fifo_pop && !fifo_empty && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #2;
        fifo_empty    = (fifo_q.size() == 0) || fifo_hold;
        fifo_data_out = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // SRAM model: stores on WE rising; one chosen write of a batch can be stored with bit0 flipped.
    logic [7:0] sram [0:65535];
    int wr_idx;
    int corrupt_idx;
    assign mem_rd_data = (!CE_bar && !OE_bar) ? sram[mem_wr_addr] : 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int mon_addr[$], mon_data[$], mon_pw[$], mon_setup[$], mon_hold[$], mon_fall[$], mon_rise[$];
    bit in_pulse, post, overlap, unstable, idle_bad;
    int setup_cnt, hold_cnt, pw;
    logic [15:0] p_addr;
    logic [7:0]  p_data;
    int verr_rise;
    bit verr_prev;

    always @(negedge clk) begin
        if (verify_err === 1'b1 && !verr_prev) verr_rise = cyc;
        verr_prev = (verify_err === 1'b1);
        if (!reset_n) begin
            if (in_pulse) begin
                void'(mon_setup.pop_back());
                void'(mon_fall.pop_back());
            end
            in_pulse = 0; post = 0; setup_cnt = 0; hold_cnt = 0;
        end else begin
            if (!OE_bar && !WE_bar) overlap = 1;
            if (CE_bar && (mem_wr_addr != 0 || mem_wr_data != 0 || mem_data_oe || !WE_bar || !OE_bar))
                idle_bad = 1;
            if (!WE_bar) begin
                if (!in_pulse) begin
                    in_pulse = 1; pw = 0; p_addr = mem_wr_addr; p_data = mem_wr_data;
                    mon_setup.push_back(setup_cnt);
                    mon_fall.push_back(cyc);
                end
                pw++;
                if (mem_wr_addr != p_addr || mem_wr_data != p_data || CE_bar || !mem_data_oe) unstable = 1;
            end else if (in_pulse) begin
                in_pulse = 0; post = 1; hold_cnt = 0;
                mon_addr.push_back(int'(p_addr));
                mon_data.push_back(int'(p_data));
                mon_pw.push_back(pw);
                mon_rise.push_back(cyc);
                sram[p_addr] = p_data ^ ((wr_idx == corrupt_idx) ? 8'h01 : 8'h00);
                wr_idx++;
            end
            if (!CE_bar && WE_bar && OE_bar && mem_data_oe) begin
                if (post) hold_cnt++;
                else if (!in_pulse) setup_cnt++;
            end
            if (CE_bar) begin
                if (post) begin
                    mon_hold.push_back(hold_cnt);
                    post = 0;
                end
                setup_cnt = 0;
            end
        end
    end

    // Reference model: byte i of a batch goes to (base + i) mod 2^16.
    int exp_addr[$], exp_data[$];

    task automatic add_byte(input logic [7:0] b);
        logic [15:0] a;
        a = cfg_base + 16'(exp_addr.size());
        exp_addr.push_back(int'(a));
        exp_data.push_back(int'(b));
        fifo_q.push_back(b);
    endtask

    task automatic setup_batch(input logic [15:0] base, input int num, input int corrupt);
        start_wr = 0; cfg_ready = 0; fifo_hold = 0;
        cfg_base = base; cfg_num = 16'(num);
        fifo_q.delete(); exp_addr.delete(); exp_data.delete();
        mon_addr.delete(); mon_data.delete(); mon_pw.delete(); mon_setup.delete();
        mon_hold.delete(); mon_fall.delete(); mon_rise.delete();
        wr_idx = 0; corrupt_idx = corrupt; verr_rise = -1;
        tick(); tick();
    endtask

    task automatic wait_done(input string tag, input int gap_pct, input int drop_pct);
        int n;
        n = 0;
        do begin
            if (gap_pct > 0) fifo_hold = ($urandom_range(99) < gap_pct);
            if (drop_pct > 0) start_wr = ($urandom_range(99) >= drop_pct);
            tick();
            n++;
        end while (!(batch_dma_done && !busy) && n < 3000);
        fifo_hold = 0; start_wr = 1;
        chk({tag, "_timeout"}, 32'(n >= 3000), 0);
        tick(); tick();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, mon_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
            chk({tag, "_addr"}, mon_addr[i], exp_addr[i]);
            chk({tag, "_data"}, mon_data[i], exp_data[i]);
            chk({tag, "_we_width"}, mon_pw[i], PULSE);
            chk({tag, "_setup"}, mon_setup[i], SETUP);
            if (i < mon_hold.size()) chk({tag, "_hold"}, mon_hold[i], HOLD);
        end
    endtask

    initial begin
        int n, cnt, k, j, num;
        logic [15:0] base;
        reset_n = 0; start_wr = 0; cfg_ready = 0; cfg_base = 0; cfg_num = 0;
        fifo_hold = 0; fifo_empty = 1; fifo_data_out = 0; corrupt_idx = -1; wr_idx = 0;
        repeat (3) tick();
        chk("rst_ce", CE_bar, 1);
        chk("rst_oe", OE_bar, 1);
        chk("rst_we", WE_bar, 1);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_data_oe", mem_data_oe, 0);
        chk("rst_addr", mem_wr_addr, 0);
        chk("rst_data", mem_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_verr", verify_err, 0);
        chk("rst_done_cntr0", batch_dma_done, 1);
        reset_n = 1;
        tick();

        // Basic batch of three bytes
        setup_batch(16'h0100, 3, -1);
        add_byte(8'hA5); add_byte(8'h3C); add_byte(8'hFF);
        start_wr = 1; cfg_ready = 1;
        tick();
        chk("basic_done_early", batch_dma_done, 0);
        wait_done("basic", 0, 0);
        check_writes("basic");
        if (mon_fall.size() >= 3) begin
            chk("basic_period01", mon_fall[1] - mon_fall[0], PER);
            chk("basic_period12", mon_fall[2] - mon_fall[1], PER);
        end
        chk("basic_done", batch_dma_done, 1);
        chk("basic_busy", busy, 0);

        // Zero-length batch
        setup_batch(16'h0040, 0, -1);
        fifo_q.push_back(8'h77);
        start_wr = 1; cfg_ready = 1;
        tick();
        chk("zero_done", batch_dma_done, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (fifo_pop || !CE_bar || busy) cnt++;
            tick();
        end
        chk("zero_activity", cnt, 0);
        chk("zero_fifo_left", fifo_q.size(), 1);

        // FIFO runs empty mid-batch
        setup_batch(16'h2000, 4, -1);
        add_byte(8'($urandom)); add_byte(8'($urandom));
        start_wr = 1; cfg_ready = 1;
        n = 0;
        while (!(mon_addr.size() == 2 && !busy) && n < 500) begin tick(); n++; end
        chk("gap_wait_timeout", 32'(n >= 500), 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || !CE_bar || !WE_bar || fifo_pop) cnt++;
        end
        chk("gap_idle", cnt, 0);
        add_byte(8'($urandom)); add_byte(8'($urandom));
        k = 0;
        do begin @(negedge clk); k++; end while (fifo_empty && k < 10);
        j = 0;
        do begin @(negedge clk); j++; end while (CE_bar && j < 10);
        chk("gap_resume", j, 1);
        wait_done("gap", 0, 0);
        check_writes("gap");

        // Address wrap
        setup_batch(16'hFFFF, 2, -1);
        add_byte(8'h11); add_byte(8'h22);
        start_wr = 1; cfg_ready = 1;
        wait_done("wrap", 0, 0);
        check_writes("wrap");

        // Readback corruption on the second byte
        setup_batch(16'h3000, 3, 1);
        add_byte(8'h5A); add_byte(8'h96); add_byte(8'hC3);
        start_wr = 1; cfg_ready = 1;
        wait_done("verify", 0, 0);
        check_writes("verify");
        chk("verify_err_set", verify_err, VER);
`ifdef SRAM_DMA_WR_VERIFY_EN
        if (mon_rise.size() >= 2) chk("verify_err_timing", verr_rise - mon_rise[1], HOLD + RDS);
`endif
        repeat (5) tick();
        chk("verify_err_sticky", verify_err, VER);
        setup_batch(16'h3000, 1, -1);
        chk("verify_err_reload", verify_err, 0);

        // Reset during the second write pulse
        setup_batch(16'h0500, 2, -1);
        add_byte(8'h01); add_byte(8'h02);
        start_wr = 1; cfg_ready = 1;
        n = 0;
        while (!(mon_addr.size() == 1 && !WE_bar) && n < 200) begin tick(); n++; end
        chk("rstmid_wait_timeout", 32'(n >= 200), 0);
        reset_n = 0;
        tick();
        chk("rstmid_ce", CE_bar, 1);
        chk("rstmid_we", WE_bar, 1);
        chk("rstmid_oe", OE_bar, 1);
        chk("rstmid_busy", busy, 0);
        cfg_num = 0;
        tick();
        chk("rstmid_cntr0", batch_dma_done, 1);
        reset_n = 1;
        tick();

        // Random batches with FIFO gaps and start_wr dropouts
        for (int b = 0; b < 10; b++) begin
            base = ($urandom_range(3) == 0) ? 16'(16'hFFFF - $urandom_range(3)) : 16'($urandom);
            num = $urandom_range(1, 6);
            setup_batch(base, num, -1);
            for (int i = 0; i < num; i++) add_byte(8'($urandom));
            start_wr = 1; cfg_ready = 1;
            wait_done("rand", 30, 15);
            check_writes("rand");
            chk("rand_done", batch_dma_done, 1);
            chk("rand_verr", verify_err, 0);
        end

        chk("oe_we_overlap", 32'(overlap), 0);
        chk("pulse_unstable", 32'(unstable), 0);
        chk("idle_outputs", 32'(idle_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
